operand_fetch: RTL

- Decode-side operand stage that sits directly upstream of the ALU. It holds the 32x32 MIPS register file and reads two source registers.
- It selects register or sign-extended immediate for operand B and registers everything into an ID/EX pipeline register.
- The registered outputs drive the ALU's scrA, scrB and ALUControl inputs directly. The write-back port accepts results returning from the ALU/memory path.

---
 rtl/mips_pkg.sv | 13 +
 rtl/regfile.sv | 42 ++++
 rtl/operand_fetch.sv | 98 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and ALU opcode encodings.
package mips_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NREGS     = 32;
    localparam int unsigned REG_IDX_W = $clog2(NREGS);

    typedef logic [3:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_ADD = 4'b0010;
    localparam alu_ctrl_t ALU_SUB = 4'b0110;

endpackage

// File: rtl/regfile.sv
// MIPS register file: two combinational read ports with write-through bypass,
// one synchronous write port, $zero hardwired.
module regfile
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = mips_pkg::DATA_W,
    parameter int unsigned NREGS  = mips_pkg::NREGS,
    parameter int unsigned IDX_W  = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [IDX_W-1:0]  ra_i,
    input  logic [IDX_W-1:0]  rb_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  wa_i,
    input  logic [DATA_W-1:0] wd_i,
    output logic [DATA_W-1:0] rda_o,
    output logic [DATA_W-1:0] rdb_o
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic              wr_en;

    assign wr_en = we_i && (wa_i != '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            regs_q <= '{default: '0};
        end else if (wr_en) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Bypass lets a write-back and a dependent read in the same cycle see the new value.
    always_comb begin
        rda_o = '0;
        rdb_o = '0;
        if (ra_i != '0) rda_o = (wr_en && wa_i == ra_i) ? wd_i : regs_q[ra_i];
        if (rb_i != '0) rdb_o = (wr_en && wa_i == rb_i) ? wd_i : regs_q[rb_i];
    end

endmodule

// File: rtl/operand_fetch.sv
// Decode-side operand stage: register read, immediate select and the ID/EX
// pipeline register feeding the ALU.
module operand_fetch #(
    parameter int unsigned DATA_W = mips_pkg::DATA_W,
    parameter int unsigned NREGS  = mips_pkg::NREGS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [$clog2(NREGS)-1:0]  rs,
    input  logic [$clog2(NREGS)-1:0]  rt,
    input  logic [15:0]               imm16,
    input  logic                      alu_src,
    input  mips_pkg::alu_ctrl_t       alu_control_in,
    input  logic                      we3,
    input  logic [$clog2(NREGS)-1:0]  wa3,
    input  logic [DATA_W-1:0]         wd3,
    output logic                      ex_valid,
    output logic [DATA_W-1:0]         scrA,
    output logic [DATA_W-1:0]         scrB,
    output mips_pkg::alu_ctrl_t       ALUControl,
    output logic [DATA_W-1:0]         ex_rt_data
);

    import mips_pkg::*;

    logic [DATA_W-1:0] rd_a, rd_b, opb;

    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] scr_a_q, scr_a_d;
    logic [DATA_W-1:0] scr_b_q, scr_b_d;
    alu_ctrl_t         alu_ctrl_q, alu_ctrl_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;

    regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk_i   (clk),
        .reset_i (reset),
        .ra_i    (rs),
        .rb_i    (rt),
        .we_i    (we3),
        .wa_i    (wa3),
        .wd_i    (wd3),
        .rda_o   (rd_a),
        .rdb_o   (rd_b)
    );

    assign opb = alu_src ? {{(DATA_W-16){imm16[15]}}, imm16} : rd_b;

    // Flush beats stall; a stalled stage still lets write-back update the regfile.
    always_comb begin
        ex_valid_d = ex_valid_q;
        scr_a_d    = scr_a_q;
        scr_b_d    = scr_b_q;
        alu_ctrl_d = alu_ctrl_q;
        rt_data_d  = rt_data_q;
        if (flush) begin
            ex_valid_d = 1'b0;
            scr_a_d    = '0;
            scr_b_d    = '0;
            alu_ctrl_d = '0;
            rt_data_d  = '0;
        end else if (!stall) begin
            ex_valid_d = in_valid;
            scr_a_d    = rd_a;
            scr_b_d    = opb;
            alu_ctrl_d = alu_control_in;
            rt_data_d  = rd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            scr_a_q    <= '0;
            scr_b_q    <= '0;
            alu_ctrl_q <= '0;
            rt_data_q  <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            scr_a_q    <= scr_a_d;
            scr_b_q    <= scr_b_d;
            alu_ctrl_q <= alu_ctrl_d;
            rt_data_q  <= rt_data_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign scrA       = scr_a_q;
    assign scrB       = scr_b_q;
    assign ALUControl = alu_ctrl_q;
    assign ex_rt_data = rt_data_q;

endmodule
